// File: rtl/l1d_mshr_bps_bankq_pkg.sv
// Shared types for the L1D MSHR bypass path and its per-bank queues.
// Bank/queue defaults plus the tag-pipe to data-RAM payload mapping.
package l1d_package;

  localparam int L1D_BANK_NUM  = 2;
  localparam int L1D_BPS_DEPTH = 2;

  localparam int IDX_W  = 8;
  localparam int OFF_W  = 6;
  localparam int WAY_W  = 2;
  localparam int DATA_W = 64;
  localparam int BE_W   = 8;
  localparam int SB_W   = 4;

  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } rw_e;

  typedef struct packed {
    logic              need_evict;
    logic              need_linefill;
    rw_e               need_rw;
    logic [IDX_W-1:0]  index;
    logic [OFF_W-1:0]  offset;
    logic [WAY_W-1:0]  way;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_data_byte_en;
    logic [SB_W-1:0]   wr_sb_pld;
  } pack_l1d_mshr_state;

  typedef struct packed {
    rw_e               rw_type;
    logic [IDX_W-1:0]  index;
    logic [OFF_W-1:0]  offset;
    logic [WAY_W-1:0]  way;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_data_byte_en;
    logic [SB_W-1:0]   wr_sb_pld;
  } pack_data_ram_req_pld;

  function automatic pack_data_ram_req_pld to_ram_pld(
    input pack_l1d_mshr_state s
  );
    pack_data_ram_req_pld p;
    p.rw_type         = s.need_rw;
    p.index           = s.index;
    p.offset          = s.offset;
    p.way             = s.way;
    p.wr_data         = s.wr_data;
    p.wr_data_byte_en = s.wr_data_byte_en;
    p.wr_sb_pld       = s.wr_sb_pld;
    return p;
  endfunction

endpackage

// File: rtl/l1d_bps_fifo.sv
// Per-bank bypass FIFO with per-entry valid bits for index probing.
// Push on a full queue succeeds only when the head leaves the same cycle.
module l1d_bps_fifo
  import l1d_package::*;
#(
  parameter int DEPTH = L1D_BPS_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  pack_data_ram_req_pld din_i,
  input  logic [IDX_W-1:0]     probe_idx_i,
  output pack_data_ram_req_pld head_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 hit_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  pack_data_ram_req_pld mem_q [DEPTH];
  logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Clear before set so a full-queue swap keeps the slot valid.
  always_comb begin
    ent_vld_d = ent_vld_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_pop) begin
      rd_ptr_d            = nxt(rd_ptr_q);
      ent_vld_d[rd_ptr_q] = 1'b0;
    end
    if (do_push) begin
      wr_ptr_d            = nxt(wr_ptr_q);
      ent_vld_d[wr_ptr_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ent_vld_q <= ent_vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld_q[i] && (mem_q[i].index == probe_idx_i)) hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/l1d_mshr_bps_bankq.sv
// MSHR bypass path to banked data RAM; per-bank order-preserving queues
// exist only when L1D_BPS_BANKQ_EN is defined, else pure pass-through.
module l1d_mshr_bps_bankq
  import l1d_package::*;
#(
  parameter int BANK_NUM  = L1D_BANK_NUM,
  parameter int BPS_DEPTH = L1D_BPS_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  pack_l1d_mshr_state                  tag_pipe_req_pld,
  input  logic                                tag_pipe_req_en,
  input  logic                                tag_pipe_hz_pass,
  input  logic [BANK_NUM-1:0]                 data_ram_rdy,
  output logic [BANK_NUM-1:0]                 mshr_bps_vld,
  output pack_data_ram_req_pld [BANK_NUM-1:0] mshr_bps_pld,
  output logic                                bps_accept,
  output logic [BANK_NUM-1:0]                 bps_full,
  output logic                                bps_index_hit
);

  localparam int BW = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

  logic                 eligible;
  logic [BW-1:0]        bank;
  logic [BANK_NUM-1:0]  sel;
  pack_data_ram_req_pld in_pld;

  assign in_pld   = to_ram_pld(tag_pipe_req_pld);
  assign eligible = !rst && tag_pipe_req_en && tag_pipe_hz_pass &&
                    !tag_pipe_req_pld.need_evict &&
                    !tag_pipe_req_pld.need_linefill;
  assign bank     = (BANK_NUM > 1) ? tag_pipe_req_pld.index[BW-1:0] : '0;

  always_comb begin
    sel = '0;
    for (int b = 0; b < BANK_NUM; b++) sel[b] = eligible && (bank == BW'(b));
  end

`ifdef L1D_BPS_BANKQ_EN
  logic [BANK_NUM-1:0] empty, full, hit, direct, push;
  pack_data_ram_req_pld [BANK_NUM-1:0] head;

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    l1d_bps_fifo #(.DEPTH(BPS_DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push[b]),
      .pop_i       (data_ram_rdy[b]),
      .din_i       (in_pld),
      .probe_idx_i (tag_pipe_req_pld.index),
      .head_o      (head[b]),
      .empty_o     (empty[b]),
      .full_o      (full[b]),
      .hit_o       (hit[b])
    );
    assign direct[b]       = sel[b] && empty[b] && data_ram_rdy[b];
    assign push[b]         = sel[b] && !direct[b] &&
                             (!full[b] || data_ram_rdy[b]);
    assign mshr_bps_vld[b] = !rst && (!empty[b] || direct[b]);
    assign mshr_bps_pld[b] = empty[b] ? in_pld : head[b];
  end

  assign bps_accept    = |(direct | push);
  assign bps_full      = full;
  assign bps_index_hit = |hit;
`else
  logic [BANK_NUM-1:0] pass;
  logic                unused_clk;

  assign unused_clk    = clk;
  assign pass          = sel & data_ram_rdy;
  assign mshr_bps_vld  = pass;
  assign bps_accept    = |pass;
  assign bps_full      = '0;
  assign bps_index_hit = 1'b0;

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    assign mshr_bps_pld[b] = in_pld;
  end
`endif

endmodule

// File: tb/tb_l1d_mshr_bps_bankq.sv
// Scoreboard bench for l1d_mshr_bps_bankq (BANK_NUM=2, BPS_DEPTH=2).
// Queue scenarios run only when L1D_BPS_BANKQ_EN is defined.
module tb_l1d_mshr_bps_bankq;
  import l1d_package::*;

  localparam int NB = 2;
  localparam int DP = 2;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  pack_l1d_mshr_state            req_pld = '0;
  logic                          req_en = 1'b0;
  logic                          hz_pass = 1'b0;
  logic [NB-1:0]                 rdy = '0;
  logic [NB-1:0]                 vld;
  pack_data_ram_req_pld [NB-1:0] pld;
  logic                          acc;
  logic [NB-1:0]                 full;
  logic                          hit;

  int checks = 0;
  int failures = 0;

  pack_data_ram_req_pld sbq [NB][$];
  logic          exp_acc, exp_hit;
  logic [NB-1:0] exp_vld, exp_full;

  l1d_mshr_bps_bankq #(.BANK_NUM(NB), .BPS_DEPTH(DP)) dut (
    .clk              (clk),
    .rst              (rst),
    .tag_pipe_req_pld (req_pld),
    .tag_pipe_req_en  (req_en),
    .tag_pipe_hz_pass (hz_pass),
    .data_ram_rdy     (rdy),
    .mshr_bps_vld     (vld),
    .mshr_bps_pld     (pld),
    .bps_accept       (acc),
    .bps_full         (full),
    .bps_index_hit    (hit)
  );

  always #5 clk = ~clk;

  pack_data_ram_req_pld mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        if (vld[b] && rdy[b]) begin
          checks++;
          if (sbq[b].size() == 0) begin
            failures++;
            $display("FAIL xfer_unexpected bank=%0d got=%h exp=none",
                     b, pld[b]);
          end else begin
            mon_e = sbq[b].pop_front();
            if (pld[b] !== mon_e) begin
              failures++;
              $display("FAIL xfer_pld bank=%0d got=%h exp=%h",
                       b, pld[b], mon_e);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] idx, input logic en,
                       input logic hz, input logic ev, input logic lf,
                       input logic [NB-1:0] r);
    pack_l1d_mshr_state   s;
    pack_data_ram_req_pld e;
    int  b, occ;
    logic elig;
    s.need_evict      = ev;
    s.need_linefill   = lf;
    s.need_rw         = rw_e'($urandom_range(0, 1));
    s.index           = idx;
    s.offset          = OFF_W'($urandom);
    s.way             = WAY_W'($urandom);
    s.wr_data         = {$urandom, $urandom};
    s.wr_data_byte_en = BE_W'($urandom);
    s.wr_sb_pld       = SB_W'($urandom);
    req_pld = s;
    req_en  = en;
    hz_pass = hz;
    rdy     = r;
    b    = int'(idx[0]);
    occ  = sbq[b].size();
    elig = en && hz && !ev && !lf;
`ifdef L1D_BPS_BANKQ_EN
    exp_acc = elig && (occ < DP || r[b]);
    exp_hit = 1'b0;
    for (int x = 0; x < NB; x++) begin
      exp_full[x] = (sbq[x].size() == DP);
      exp_vld[x]  = (sbq[x].size() > 0) ||
                    (x == b && elig && occ == 0 && r[b]);
      foreach (sbq[x][k]) if (sbq[x][k].index == idx) exp_hit = 1'b1;
    end
`else
    exp_acc  = elig && r[b];
    exp_vld  = exp_acc ? NB'(1 << b) : '0;
    exp_full = '0;
    exp_hit  = 1'b0;
`endif
    if (exp_acc) begin
      e.rw_type         = s.need_rw;
      e.index           = s.index;
      e.offset          = s.offset;
      e.way             = s.way;
      e.wr_data         = s.wr_data;
      e.wr_data_byte_en = s.wr_data_byte_en;
      e.wr_sb_pld       = s.wr_sb_pld;
      sbq[b].push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks += 4;
    if (vld !== '0) begin
      failures++; $display("FAIL rst_vld got=%b exp=00", vld);
    end
    if (full !== '0) begin
      failures++; $display("FAIL rst_full got=%b exp=00", full);
    end
    if (acc !== 1'b0) begin
      failures++; $display("FAIL rst_acc got=%b exp=0", acc);
    end
    if (hit !== 1'b0) begin
      failures++; $display("FAIL rst_hit got=%b exp=0", hit);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_direct_pass();
    tick();
    drive(8'h10, 1, 1, 0, 0, 2'b11);
    checks += 3;
    if (acc !== 1'b1) begin
      failures++; $display("FAIL dp_acc got=%b exp=1", acc);
    end
    if (vld !== 2'b01) begin
      failures++; $display("FAIL dp_vld got=%b exp=01", vld);
    end
    if (full !== 2'b00) begin
      failures++; $display("FAIL dp_full got=%b exp=00", full);
    end
    tick();
    drive(8'h10, 0, 1, 0, 0, 2'b00);
    checks++;
    if (vld !== 2'b00) begin
      failures++; $display("FAIL dp_occ_vld got=%b exp=00", vld);
    end
  endtask

  task automatic test_ineligible();
    tick();
    drive(8'h04, 1, 1, 0, 1, 2'b11);
    checks += 2;
    if (vld !== 2'b00 || acc !== 1'b0) begin
      failures++; $display("FAIL inel_lf got=%b/%b exp=00/0", vld, acc);
    end
    if (hit !== 1'b0) begin
      failures++; $display("FAIL inel_lf_hit got=%b exp=0", hit);
    end
    tick();
    drive(8'h05, 1, 0, 0, 0, 2'b11);
    checks++;
    if (vld !== 2'b00 || acc !== 1'b0) begin
      failures++; $display("FAIL inel_hz got=%b/%b exp=00/0", vld, acc);
    end
    tick();
    drive(8'h07, 1, 1, 1, 0, 2'b11);
    checks++;
    if (vld !== 2'b00 || acc !== 1'b0) begin
      failures++; $display("FAIL inel_ev got=%b/%b exp=00/0", vld, acc);
    end
  endtask

`ifdef L1D_BPS_BANKQ_EN
  task automatic test_fill_drain();
    logic [2:0] acc_seq;
    tick(); drive(8'h00, 1, 1, 0, 0, 2'b10); acc_seq[0] = acc;
    checks++;
    if (vld[0] !== 1'b0) begin
      failures++; $display("FAIL fill_vld0 got=%b exp=0", vld[0]);
    end
    tick(); drive(8'h02, 1, 1, 0, 0, 2'b10); acc_seq[1] = acc;
    tick(); drive(8'h04, 1, 1, 0, 0, 2'b10); acc_seq[2] = acc;
    checks += 2;
    if (acc_seq !== 3'b011) begin
      failures++; $display("FAIL fill_acc got=%b exp=011", acc_seq);
    end
    if (full[0] !== 1'b1) begin
      failures++; $display("FAIL fill_full got=%b exp=1", full[0]);
    end
    tick(); drive(8'h00, 0, 0, 0, 0, 2'b11);
    tick(); drive(8'h00, 0, 0, 0, 0, 2'b11);
    tick(); drive(8'h00, 0, 0, 0, 0, 2'b11);
    checks++;
    if (vld !== 2'b00) begin
      failures++; $display("FAIL drain_vld got=%b exp=00", vld);
    end
  endtask

  task automatic test_full_swap();
    tick(); drive(8'h00, 1, 1, 0, 0, 2'b10);
    tick(); drive(8'h02, 1, 1, 0, 0, 2'b10);
    tick(); drive(8'h04, 1, 1, 0, 0, 2'b11);
    checks += 2;
    if (acc !== 1'b1) begin
      failures++; $display("FAIL swap_acc got=%b exp=1", acc);
    end
    if (full[0] !== 1'b1) begin
      failures++; $display("FAIL swap_full got=%b exp=1", full[0]);
    end
    tick(); drive(8'h00, 0, 0, 0, 0, 2'b10);
    checks++;
    if (full[0] !== 1'b1) begin
      failures++; $display("FAIL swap_full_nxt got=%b exp=1", full[0]);
    end
    tick(); drive(8'h00, 0, 0, 0, 0, 2'b11);
    tick(); drive(8'h00, 0, 0, 0, 0, 2'b11);
  endtask

  task automatic test_index_hit_reset();
    tick(); drive(8'h22, 1, 1, 0, 0, 2'b00);
    checks++;
    if (hit !== 1'b0) begin
      failures++; $display("FAIL hit_direct got=%b exp=0", hit);
    end
    tick(); drive(8'h22, 0, 0, 0, 0, 2'b00);
    checks++;
    if (hit !== 1'b1) begin
      failures++; $display("FAIL hit_pend got=%b exp=1", hit);
    end
    rst = 1'b1;
    for (int b = 0; b < NB; b++) sbq[b].delete();
    tick();
    checks += 2;
    if (vld !== 2'b00) begin
      failures++; $display("FAIL hit_rst_vld got=%b exp=00", vld);
    end
    if (hit !== 1'b0) begin
      failures++; $display("FAIL hit_rst_hit got=%b exp=0", hit);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
`else
  task automatic test_no_queue();
    tick();
    drive(8'h01, 1, 1, 0, 0, 2'b01);
    checks += 3;
    if (acc !== 1'b0) begin
      failures++; $display("FAIL nq_acc got=%b exp=0", acc);
    end
    if (vld !== 2'b00) begin
      failures++; $display("FAIL nq_vld got=%b exp=00", vld);
    end
    if (full !== 2'b00) begin
      failures++; $display("FAIL nq_full got=%b exp=00", full);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] idx;
    logic en, hz, ev, lf;
    logic [NB-1:0] r;
    for (int n = 0; n < 60; n++) begin
      idx = 8'($urandom_range(0, 7));
      en  = ($urandom_range(0, 3) != 0);
      hz  = ($urandom_range(0, 7) != 0);
      ev  = ($urandom_range(0, 9) == 0);
      lf  = ($urandom_range(0, 9) == 0);
      r   = NB'($urandom);
      tick();
      drive(idx, en, hz, ev, lf, r);
      checks += 4;
      if (acc !== exp_acc) begin
        failures++; $display("FAIL rnd_acc n=%0d got=%b exp=%b", n, acc, exp_acc);
      end
      if (vld !== exp_vld) begin
        failures++; $display("FAIL rnd_vld n=%0d got=%b exp=%b", n, vld, exp_vld);
      end
      if (full !== exp_full) begin
        failures++; $display("FAIL rnd_full n=%0d got=%b exp=%b", n, full, exp_full);
      end
      if (hit !== exp_hit) begin
        failures++; $display("FAIL rnd_hit n=%0d got=%b exp=%b", n, hit, exp_hit);
      end
    end
  endtask

  task automatic test_drain_end();
    for (int n = 0; n < DP + 2; n++) begin
      tick();
      drive(8'h00, 0, 0, 0, 0, 2'b11);
    end
    @(negedge clk);
    #1;
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (sbq[b].size() != 0) begin
        failures++;
        $display("FAIL end_pending bank=%0d got=%0d exp=0", b, sbq[b].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct_pass();
    test_ineligible();
`ifdef L1D_BPS_BANKQ_EN
    test_fill_drain();
    test_full_swap();
    test_index_hit_reset();
`else
    test_no_queue();
`endif
    test_random();
    test_drain_end();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l1d_mshr_bps_bankq.md
L1D_MSHR_BPS_BANKQ -- requirements
Module: l1d_mshr_bps_bankq

Interface
REQ-001 Parameter BANK_NUM, default 2: number of data-RAM banks (power of two, 1..8).
REQ-002 Parameter BPS_DEPTH, default 2: bypass queue entries per bank (1..8).
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tag_pipe_req_pld  input  pack_l1d_mshr_state  tag-pipe request state.
REQ-006 tag_pipe_req_en  input  1  tag-pipe request valid this cycle.
REQ-007 tag_pipe_hz_pass  input  1  request cleared hazard check.
REQ-008 data_ram_rdy  input  BANK_NUM  per-bank data-RAM ready.
REQ-009 mshr_bps_vld  output  BANK_NUM  per-bank data-RAM request valid.
REQ-010 mshr_bps_pld  output  BANK_NUM x pack_data_ram_req_pld  per-bank request payload.
REQ-011 bps_accept  output  1  this cycle's tag-pipe request was taken by the bypass path; when 0 the request goes to the MSHR allocation path.
REQ-012 bps_full  output  BANK_NUM  per-bank queue full.
REQ-013 bps_index_hit  output  1  tag_pipe_req_pld.index matches any pending queue entry in any bank.

Function
REQ-014 eligible = tag_pipe_req_en && tag_pipe_hz_pass && !need_evict && !need_linefill.
REQ-015 Target bank b = tag_pipe_req_pld.index[log2(BANK_NUM)-1:0]; for BANK_NUM=1, b=0.
REQ-016 Payload mapping: rw_type<-need_rw; index, offset, way, wr_data, wr_data_byte_en, wr_sb_pld copied field-for-field.
REQ-017 Transfer on bank b occurs when mshr_bps_vld[b] && data_ram_rdy[b].
REQ-018 Queue empty, eligible, rdy[b]=1: same-cycle direct pass (vld[b]=1, pld=incoming), zero latency, no enqueue.
REQ-019 Queue empty, eligible, rdy[b]=0: enqueue; vld[b] asserts next cycle.
REQ-020 Queue non-empty: vld[b]=1 with head payload; an eligible request to b is enqueued behind the head, never passed directly (strict per-bank order).
REQ-021 Simultaneous head dequeue and enqueue on a full queue is permitted; the queue stays full and bps_accept=1.
REQ-022 Full queue with no dequeue this cycle: bps_accept=0 and the request is not stored.
REQ-023 bps_accept = eligible && (direct pass || enqueue).
REQ-024 Banks operate independently; only one request per cycle enters, at most one bank.
REQ-025 Pointers wrap modulo BPS_DEPTH; occupancy counter is clog2(BPS_DEPTH+1) bits.
REQ-026 bps_index_hit is combinational over valid entries only; direct-pass requests never assert it.

Reset
REQ-027 rst asserts: all queues empty, pointers and counters 0, mshr_bps_vld=0, bps_full=0, bps_accept=0 (with tag_pipe_req_en low), bps_index_hit=0.
REQ-028 Reset mid-operation discards all queued entries; no transfer in the cycle rst is high.
REQ-029 mshr_bps_pld is don't-care while its vld bit is 0.

Configuration
REQ-030 Macro L1D_BPS_BANKQ_EN defined: queueing per REQ-019..REQ-022.
REQ-031 Macro undefined: no queue storage; bps_accept = eligible && rdy[b]; vld[b] = bps_accept targeting b; bps_full=0; bps_index_hit=0; purely combinational per bank.

Structure
REQ-032 pack_l1d_mshr_state, pack_data_ram_req_pld, and the BANK_NUM and BPS_DEPTH defaults reside in l1d_package.
REQ-033 One sub-module l1d_bps_fifo (per-bank FIFO, payload pack_data_ram_req_pld, depth BPS_DEPTH) instantiated BANK_NUM times via generate.

Verification
REQ-034 Empty queues, eligible index=0x10 (bank 0), rdy=2'b11 -> vld=2'b01 same cycle, bps_accept=1, no occupancy change.
REQ-035 rdy[0]=0, three eligible bank-0 requests, BPS_DEPTH=2 -> first two accepted, third bps_accept=0, bps_full[0]=1; then rdy[0]=1 -> pld drains in arrival order over 2 cycles.
REQ-036 Full bank 0, rdy[0]=1, new bank-0 request -> head dequeued, new request enqueued, bps_accept=1, bps_full[0] stays 1.
REQ-037 need_linefill=1 or hz_pass=0 with rdy=all ones -> vld=0, bps_accept=0.
REQ-038 Entry index 0x22 pending in bank 0, probe index 0x22 -> bps_index_hit=1; assert rst -> next cycle vld=0, bps_index_hit=0.
REQ-039 Build without L1D_BPS_BANKQ_EN, rdy[1]=0, eligible index=0x01 -> bps_accept=0, vld=0, bps_full=0.
